// File: rtl/pulse_gen_pkg.sv
// Shared types and constants for the pulse_gen tick/pulse generator.
package pulse_gen_pkg;

  // Widest counter/config a channel can hold; CNT_W must not exceed this.
  localparam int unsigned DEF_CNT_W      = 32;
  localparam int unsigned REFRESH_60HZ_P = 833333;    // 60 Hz at 50 MHz
  localparam int unsigned PPS_50MHZ_P    = 49999999;  // 1 Hz at 50 MHz

  typedef struct packed {
    logic [DEF_CNT_W-1:0] period;
    logic [DEF_CNT_W-1:0] high;
    logic                 oneshot;
  } ch_cfg_t;

  typedef enum logic {StIdle, StRun} os_state_t;

  function automatic ch_cfg_t make_cfg(input logic [DEF_CNT_W-1:0] period,
                                       input logic [DEF_CNT_W-1:0] high,
                                       input logic                 oneshot);
    ch_cfg_t c;
    c.period  = period;
    c.high    = high;
    c.oneshot = oneshot;
    return c;
  endfunction

endpackage

// File: rtl/pulse_gen_ch.sv
// Single tick/pulse channel: counter, staged config and optional one-shot FSM.
// One-shot support is built only when PULSE_GEN_ONESHOT_EN is defined.
module pulse_gen_ch
  import pulse_gen_pkg::*;
#(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned DEF_PERIOD = REFRESH_60HZ_P,
  parameter int unsigned DEF_HIGH   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic             cfg_oneshot,
  input  logic             en,
  input  logic             trig,
  output logic             tick,
  output logic             pulse,
  output logic             busy
);

  ch_cfg_t          cfg_q, cfg_d, stg_q, stg_d, new_cfg, rst_cfg;
  logic             stg_vld_q, stg_vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, per, hi;
  logic             run, wrap;

  assign per     = cfg_q.period[CNT_W-1:0];
  assign hi      = cfg_q.high[CNT_W-1:0];
  assign rst_cfg = make_cfg(DEF_CNT_W'(DEF_PERIOD), DEF_CNT_W'(DEF_HIGH), 1'b0);
  assign wrap    = run && (cnt_q == per);

`ifdef PULSE_GEN_ONESHOT_EN
  os_state_t state_q, state_d;

  assign new_cfg = make_cfg(DEF_CNT_W'(cfg_period), DEF_CNT_W'(cfg_high), cfg_oneshot);
  // A one-shot channel counts only while armed, or on the trigger cycle itself.
  assign run     = en && (!cfg_q.oneshot || (state_q == StRun) || trig);

  // One-shot FSM: arm on trigger, disarm on wrap; a disabled-channel write aborts.
  always_comb begin
    state_d = state_q;
    if (!en) begin
      if (cfg_we) state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (cfg_q.oneshot && trig && !wrap) state_d = StRun;
        StRun:   if (wrap) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // One-shot state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end
`else
  logic unused_oneshot;

  assign new_cfg        = make_cfg(DEF_CNT_W'(cfg_period), DEF_CNT_W'(cfg_high), 1'b0);
  assign run            = en;
  assign unused_oneshot = ^{trig, cfg_oneshot, cfg_q.oneshot};
`endif

  // Counter and config update: immediate when disabled, staged to the wrap when enabled.
  always_comb begin
    cnt_d     = cnt_q;
    cfg_d     = cfg_q;
    stg_d     = stg_q;
    stg_vld_d = stg_vld_q;
    if (!en) begin
      if (cfg_we) begin
        cfg_d     = new_cfg;
        cnt_d     = '0;
        stg_vld_d = 1'b0;
      end
    end else begin
      if (run) cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
      if (wrap) begin
        // A write landing on the wrap cycle is newest, so it beats the staged copy.
        if (cfg_we)         cfg_d = new_cfg;
        else if (stg_vld_q) cfg_d = stg_q;
        stg_vld_d = 1'b0;
      end else if (cfg_we) begin
        stg_d     = new_cfg;
        stg_vld_d = 1'b1;
      end
    end
  end

  // State and registered outputs, all derived from the pre-update counter/config.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      cfg_q     <= rst_cfg;
      stg_q     <= rst_cfg;
      stg_vld_q <= 1'b0;
      tick      <= 1'b0;
      pulse     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      cfg_q     <= cfg_d;
      stg_q     <= stg_d;
      stg_vld_q <= stg_vld_d;
      tick      <= run && (cnt_q == per);
      pulse     <= run && (cnt_q < hi);
      busy      <= run;
    end
  end

endmodule

// File: rtl/pulse_gen.sv
// Multi-channel tick/pulse generator; one pulse_gen_ch per channel.
// Define PULSE_GEN_ONESHOT_EN to enable per-channel one-shot mode and trig.
module pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned DEF_PERIOD = REFRESH_60HZ_P,
  parameter int unsigned DEF_HIGH   = 0,
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_high,
  input  logic              cfg_oneshot,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [NUM_CH-1:0] trig,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pulse,
  output logic [NUM_CH-1:0] busy
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic we;

    // Out-of-range channel numbers match no instance and are dropped.
    assign we = cfg_we && (cfg_ch == CH_W'(i));

    pulse_gen_ch #(
      .CNT_W      (CNT_W),
      .DEF_PERIOD (DEF_PERIOD),
      .DEF_HIGH   (DEF_HIGH)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .cfg_we      (we),
      .cfg_period  (cfg_period),
      .cfg_high    (cfg_high),
      .cfg_oneshot (cfg_oneshot),
      .en          (ch_en[i]),
      .trig        (trig[i]),
      .tick        (tick[i]),
      .pulse       (pulse[i]),
      .busy        (busy[i])
    );
  end

endmodule

// File: tb/tb_pulse_gen.sv
// Directed self-checking bench for pulse_gen. The reset period is scaled down
// to 11 so default-period ticking is observable in a short run.
module tb_pulse_gen;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned TB_P   = 11;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_we;
  logic [1:0]        cfg_ch;
  logic [CNT_W-1:0]  cfg_period;
  logic [CNT_W-1:0]  cfg_high;
  logic              cfg_oneshot;
  logic [NUM_CH-1:0] ch_en;
  logic [NUM_CH-1:0] trig;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] pulse;
  logic [NUM_CH-1:0] busy;

  int vectors     = 0;
  int miscompares = 0;

  pulse_gen #(
    .NUM_CH     (NUM_CH),
    .CNT_W      (CNT_W),
    .DEF_PERIOD (TB_P),
    .DEF_HIGH   (0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_period  (cfg_period),
    .cfg_high    (cfg_high),
    .cfg_oneshot (cfg_oneshot),
    .ch_en       (ch_en),
    .trig        (trig),
    .tick        (tick),
    .pulse       (pulse),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare {tick, pulse, busy} against the expected 12-bit vector.
  task automatic check(input string tag, input logic [11:0] exp);
    logic [11:0] obs;
    obs = {tick, pulse, busy};
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed tick/pulse/busy=%h required=%h", tag, obs, exp);
    end
  endtask

  // Configure a disabled channel in one cycle.
  task automatic cfg_write(input logic [1:0] ch, input int unsigned p, input int unsigned h,
                           input logic os);
    cfg_ch      = ch;
    cfg_period  = p;
    cfg_high    = h;
    cfg_oneshot = os;
    cfg_we      = 1'b1;
    step();
    cfg_we      = 1'b0;
  endtask

  initial begin
    logic [3:0] t, p;
    int unsigned c, per;

    rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_high = '0;
    cfg_oneshot = 1'b0; ch_en = '0; trig = '0;

    // Reset state
    step(); step();
    check("reset", 12'h000);

    // Default config on channel 0: P=11, H=0
    rst = 1'b0;
    ch_en = 4'b0001;
    for (int k = 1; k <= 30; k++) begin
      step();
      t = (k % 12 == 0) ? 4'b0001 : 4'b0000;
      check($sformatf("ch0_default_k%0d", k), {t, 4'b0000, 4'b0001});
    end
    ch_en = 4'b0000;
    step();
    check("ch0_off", 12'h000);

    // Channel 1: P=9, H=3 written while disabled
    cfg_write(2'd1, 9, 3, 1'b0);
    check("ch1_cfg_disabled", 12'h000);
    ch_en = 4'b0010;
    for (int k = 1; k <= 25; k++) begin
      step();
      c = (k - 1) % 10;
      t = (c == 9) ? 4'b0010 : 4'b0000;
      p = (c < 3)  ? 4'b0010 : 4'b0000;
      check($sformatf("ch1_p9_k%0d", k), {t, p, 4'b0010});
    end

    // Staged write P=4 while cnt=5: old period finishes, then period 5
    cfg_period = 4;
    cfg_high   = 3;
    for (int k = 26; k <= 43; k++) begin
      cfg_we = (k == 26);
      step();
      cfg_we = 1'b0;
      if (k <= 30) begin
        c = (k - 1) % 10; per = 9;
      end else begin
        c = (k - 31) % 5; per = 4;
      end
      t = (c == per) ? 4'b0010 : 4'b0000;
      p = (c < 3)    ? 4'b0010 : 4'b0000;
      check($sformatf("ch1_staged_k%0d", k), {t, p, 4'b0010});
    end

    // Freeze at cnt=3 for three cycles, then resume from 3
    ch_en = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("ch1_frozen_%0d", k), 12'h000);
    end
    ch_en = 4'b0010;
    step(); check("ch1_resume_cnt3", {4'b0000, 4'b0000, 4'b0010});
    step(); check("ch1_resume_cnt4", {4'b0010, 4'b0000, 4'b0010});
    step(); check("ch1_resume_cnt0", {4'b0000, 4'b0010, 4'b0010});
    ch_en = 4'b0000;
    step();
    check("ch1_off", 12'h000);

    // Channel 2: P=0 ticks every cycle, H=5 > P holds pulse high
    cfg_write(2'd2, 0, 5, 1'b0);
    ch_en = 4'b0100;
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("ch2_p0_k%0d", k), {4'b0100, 4'b0100, 4'b0100});
    end
    ch_en = 4'b0000;
    for (int k = 0; k < 7; k++) begin
      step();
      check($sformatf("ch2_disabled_%0d", k), 12'h000);
    end
    ch_en = 4'b0100;
    for (int k = 1; k <= 3; k++) begin
      step();
      check($sformatf("ch2_resumed_k%0d", k), {4'b0100, 4'b0100, 4'b0100});
    end
    ch_en = 4'b0000;
    step();

`ifdef PULSE_GEN_ONESHOT_EN
    // Channel 3 one-shot, P=7: busy 8 cycles, one tick, retrigger ignored
    cfg_write(2'd3, 7, 0, 1'b1);
    ch_en = 4'b1000;
    step(); step();
    check("ch3_idle", 12'h000);
    for (int j = 0; j <= 9; j++) begin
      trig = (j == 0 || j == 3) ? 4'b1000 : 4'b0000;
      step();
      trig = 4'b0000;
      t = (j == 7) ? 4'b1000 : 4'b0000;
      check($sformatf("ch3_oneshot_j%0d", j), {t, 4'b0000, (j <= 7) ? 4'b1000 : 4'b0000});
    end
    trig = 4'b1000;
    step();
    trig = 4'b0000;
    check("ch3_retrig", {4'b0000, 4'b0000, 4'b1000});
    step();
    check("ch3_running", {4'b0000, 4'b0000, 4'b1000});
`else
    // Without one-shot support the mode bit and trig are ignored: periodic P=7
    cfg_write(2'd3, 7, 0, 1'b1);
    ch_en = 4'b1000;
    for (int k = 1; k <= 10; k++) begin
      trig = (k == 1 || k == 4) ? 4'b1000 : 4'b0000;
      step();
      trig = 4'b0000;
      t = (k == 8) ? 4'b1000 : 4'b0000;
      check($sformatf("ch3_periodic_k%0d", k), {t, 4'b0000, 4'b1000});
    end
`endif

    // Asynchronous reset mid-run clears outputs without waiting for a clock edge
    rst = 1'b1;
    #1;
    check("rst_async", 12'h000);
    ch_en = 4'b0000;
    step();
    rst = 1'b0;
    step();
    check("post_rst", 12'h000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
